sub_serial: RTL and testbench
=============================

// Module: sub_serial
//
// PURPOSE
//   Bit-serial unsigned subtractor: out = a - b (mod 2^WIDTH), borrow = (a < b).
//   It is the inverse-direction counterpart of the team's bit-serial adder.
//   Operands are captured on en and processed LSB first, one bit per clock.
//   The result is held with done asserted until the consumer returns ack.
//
// PARAMETERS
//   WIDTH  8  operand/result width in bits; must be >= 2
//
// PORTS
//   clk     in   1      rising-edge clock, single clock domain
//   rst     in   1      synchronous, active-high reset
//   en      in   1      start request; sampled only in IDLE
//   a       in   WIDTH  minuend; captured when en is accepted
//   b       in   WIDTH  subtrahend; captured when en is accepted
//   ack     in   1      result consumed; sampled only in DONE
//   out     out  WIDTH  difference; valid only while done=1
//   borrow  out  1      final borrow (1 iff a < b); valid only while done=1
//   busy    out  1      1 in SUB (decoded from state)
//   done    out  1      1 in DONE (decoded from state)
//
// BEHAVIOUR
//   Reset (rst=1 at a rising edge): state=IDLE; a_reg, b_reg, out, count,
//     bor and borrow all 0; busy=0, done=0. rst has priority over all inputs.
//     rst asserted mid-SUB or mid-DONE aborts the operation; no partial result is kept.
//   Registers: a_reg/b_reg WIDTH bits; count $clog2(WIDTH) bits; bor = running borrow.
//   IDLE:
//     - en=1: a_reg<=a, b_reg<=b, count<=0, bor<=0, out<=0; next state SUB.
//     - en=0: hold all registers.
//   SUB, once per clock:
//     - d      = a_reg[0] ^ b_reg[0] ^ bor
//     - bor_n  = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & bor) | (b_reg[0] & bor)
//     - out <= {d, out[WIDTH-1:1]}; a_reg <= a_reg>>1; b_reg <= b_reg>>1;
//       bor <= bor_n; count <= count+1.
//     - When count==WIDTH-1: also borrow <= bor_n; next state DONE.
//     - en is ignored.
//   DONE:
//     - out and borrow hold.
//     - ack=1: next state IDLE; out and borrow keep their values until the next accepted en.
//     - en is ignored. en=1 together with ack=1 does NOT start a new operation;
//       en must be presented again in IDLE.
//   Latency: en accepted at edge k; SUB spans edges k+1..k+WIDTH; done=1 from
//     the cycle after edge k+WIDTH. Minimum start-to-start interval is WIDTH+2
//     cycles (ack given on the first DONE cycle).
//   Undefined state encoding: next state IDLE, registers hold.
//   ack outside DONE and en outside IDLE have no effect.
//   Width rule: all arithmetic is modulo 2^WIDTH; count wraps only via the state exit.
//
// TESTING
//   1. WIDTH=8, a=0x05, b=0x03, en for 1 cycle -> done after 8 SUB cycles;
//      out=0x02, borrow=0.
//   2. a=0x03, b=0x05 -> out=0xFE, borrow=1.
//      a=0x00, b=0xFF -> out=0x01, borrow=1.
//   3. a=0x00, b=0x00 -> out=0x00, borrow=0.
//      a=0xFF, b=0xFF -> out=0x00, borrow=0.
//      a=0x80, b=0x01 -> out=0x7F, borrow=0.
//   4. Hold done with ack=0 for 20 cycles while toggling en, a and b
//      -> out and borrow stable, done stays 1.
//      Then ack=1 with en=1 -> IDLE, no new start.
//   5. rst=1 on the 4th SUB cycle -> next cycle state IDLE, out=0, borrow=0,
//      busy=0, done=0. A fresh en then completes correctly.
//   6. Back-to-back operations (ack on the first DONE cycle, en on the next IDLE cycle)
//      -> WIDTH+2 cycle cadence. 1000 random pairs checked against a-b in the model.

Source files
------------

// File: rtl/sub_serial.sv
// rtl/sub_serial.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
// Result and final borrow are held with done until the consumer acknowledges.
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             borrow_q, borrow_d;
  logic             diff_bit;
  logic             bor_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = SUB;
      SUB:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SUB);
    done = (state_q == DONE);
  end

  // Full-subtractor cell applied to the current LSBs of the shifting operands.
  assign diff_bit = a_q[0] ^ b_q[0] ^ bor_q;
  assign bor_n    = (~a_q[0] & b_q[0]) | (~a_q[0] & bor_q) | (b_q[0] & bor_q);

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    bor_d    = bor_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          a_d   = a;
          b_d   = b;
          cnt_d = '0;
          bor_d = 1'b0;
          out_d = '0;
        end
      end
      SUB: begin
        out_d = {diff_bit, out_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bor_d = bor_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) borrow_d = bor_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      bor_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      bor_q    <= bor_d;
      borrow_q <= borrow_d;
    end
  end

  assign out    = out_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_sub_serial.sv
// tb/tb_sub_serial.sv - directed and random checks of sub_serial (WIDTH=8)
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sub_serial;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ack;
  logic [WIDTH-1:0] out;
  logic             borrow;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  sub_serial #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a      (a),
    .b      (b),
    .ack    (ack),
    .out    (out),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts an operation, checks the exact start-to-done latency and the result, leaves DONE held.
  task automatic start_and_wait(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic [WIDTH-1:0] eo, input logic eb, input string tag);
    int cyc;
    en = 1'b1; a = av; b = bv;
    @(negedge clk);
    en = 1'b0; a = $urandom; b = $urandom;
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_out"}, {24'd0, out}, {24'd0, eo});
    check({tag, "_borrow"}, {31'd0, borrow}, {31'd0, eb});
  endtask

  task automatic ack_now(input string tag);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb, hold_out;
    logic             hold_bor;
    rst = 1'b1; en = 1'b0; ack = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_out", {24'd0, out}, 32'd0);
    check("reset_flags", {29'd0, borrow, busy, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    start_and_wait(8'h05, 8'h03, 8'h02, 1'b0, "t1"); ack_now("t1");
    start_and_wait(8'h03, 8'h05, 8'hFE, 1'b1, "t2a"); ack_now("t2a");
    start_and_wait(8'h00, 8'hFF, 8'h01, 1'b1, "t2b"); ack_now("t2b");
    start_and_wait(8'h00, 8'h00, 8'h00, 1'b0, "t3a"); ack_now("t3a");
    start_and_wait(8'hFF, 8'hFF, 8'h00, 1'b0, "t3b"); ack_now("t3b");
    start_and_wait(8'h80, 8'h01, 8'h7F, 1'b0, "t3c"); ack_now("t3c");

    // Hold DONE while en/a/b toggle; the result must not move.
    start_and_wait(8'h10, 8'h20, 8'hF0, 1'b1, "t4");
    hold_out = out; hold_bor = borrow;
    for (int i = 0; i < 20; i++) begin
      en = i[0]; a = $urandom; b = $urandom;
      @(negedge clk);
      check("t4_hold", {23'd0, out, borrow, done}, {23'd0, 8'hF0, 1'b1, 1'b1});
    end
    en = 1'b1; ack = 1'b1;
    @(negedge clk);
    en = 1'b0; ack = 1'b0;
    check("t4_ack_en_idle", {30'd0, busy, done}, 32'd0);
    check("t4_out_kept", {23'd0, out, borrow}, {23'd0, hold_out, hold_bor});
    @(negedge clk);
    check("t4_no_start", {30'd0, busy, done}, 32'd0);

    // Abort on the 4th SUB cycle; borrow=1 is still held from the previous operation.
    en = 1'b1; a = 8'h33; b = 8'h11;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_after_rst", {21'd0, out, borrow, busy, done}, 32'd0);
    start_and_wait(8'h33, 8'h11, 8'h22, 1'b0, "t5_fresh"); ack_now("t5_fresh");

    // Back-to-back random operations at the minimum cadence.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      start_and_wait(ra, rb, ra - rb, (ra < rb), "t6");
      ack_now("t6");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
